// File: rtl/mmio_bank.sv
// +--------------------------------------------------------------------------+
// | mmio_bank: byte-addressed MMIO register bank with valid/ready handshake, |
// | read/write windows, write readback, byte strobes and error responses.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mmio_bank #(
  parameter logic [31:0] IO_BASE     = 32'h1000_0000,
  parameter logic [31:0] WR_OFFSET   = 32'h0000_8000,
  parameter int          RD_BYTES    = 64,
  parameter int          WR_BYTES    = 64,
  parameter int          ALIGN_CHECK = 1,
  parameter logic [7:0]  WR_RESET    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_dw,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  input  logic [8*RD_BYTES-1:0] io_r,
  output logic [8*WR_BYTES-1:0] io_w,
  output logic [WR_BYTES-1:0]   io_w_stb
);

  localparam int          RA        = $clog2(RD_BYTES);
  localparam int          WA        = $clog2(WR_BYTES);
  localparam logic [31:0] c_wr_base = IO_BASE + WR_OFFSET;

  if (WR_OFFSET < 32'(RD_BYTES)) begin : g_overlap_err
    $error("mmio_bank: write window overlaps read window");
  end

  logic [7:0]          r_io_w [WR_BYTES];
  logic [7:0]          w_io_r_b [RD_BYTES];
  logic [WR_BYTES-1:0] r_stb;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;

  for (genvar g = 0; g < WR_BYTES; g++) begin : g_pack_w
    assign io_w[8*g +: 8] = r_io_w[g];
  end
  for (genvar g = 0; g < RD_BYTES; g++) begin : g_unpack_r
    assign w_io_r_b[g] = io_r[8*g +: 8];
  end

  logic [2:0]          w_n;
  logic [31:0]         w_rd_off;
  logic [31:0]         w_wr_off;
  logic                w_rd_fit;
  logic                w_wr_hit;
  logic                w_wr_fit;
  logic [1:0]          w_off_lo;
  logic                w_aligned;
  logic                w_legal;
  logic                w_accept;
  logic                w_wr_en;
  logic [RA-1:0]       w_rd_idx;
  logic [WA-1:0]       w_wr_idx;
  logic [31:0]         w_rdata;
  logic [WR_BYTES-1:0] w_be;

  always_comb begin
    w_n = 3'd0;
    case (req_dw)
      2'd0:    w_n = 3'd1;
      2'd1:    w_n = 3'd2;
      2'd2:    w_n = 3'd4;
      default: w_n = 3'd0;
    endcase
  end

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // Offsets wrap below the base, so a single unsigned compare covers both ends.
  assign w_rd_off  = req_addr - IO_BASE;
  assign w_wr_off  = req_addr - c_wr_base;
  assign w_rd_fit  = (w_rd_off < 32'(RD_BYTES)) &&
                     ((w_rd_off + 32'(w_n) - 32'd1) < 32'(RD_BYTES));
  assign w_wr_hit  = w_wr_off < 32'(WR_BYTES);
  assign w_wr_fit  = w_wr_hit && ((w_wr_off + 32'(w_n) - 32'd1) < 32'(WR_BYTES));
  assign w_off_lo  = w_wr_hit ? w_wr_off[1:0] : w_rd_off[1:0];
  assign w_aligned = (ALIGN_CHECK == 0) || ((w_off_lo & (w_n[1:0] - 2'd1)) == 2'b00);
  // A start inside the write window never falls back to the read window.
  assign w_legal   = (req_dw != 2'd3) && w_aligned &&
                     (w_wr_hit ? w_wr_fit : (w_rd_fit && !req_we));
  assign w_wr_en   = w_accept && w_legal && req_we;
  assign w_rd_idx  = w_rd_off[RA-1:0];
  assign w_wr_idx  = w_wr_off[WA-1:0];

  always_comb begin
    w_rdata = '0;
    w_be    = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_n) begin
        if (w_wr_hit) w_rdata[8*i +: 8] = r_io_w[w_wr_idx + WA'(i)];
        else          w_rdata[8*i +: 8] = w_io_r_b[w_rd_idx + RA'(i)];
        if (w_wr_en)  w_be[w_wr_idx + WA'(i)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_stb       <= '0;
      for (int j = 0; j < WR_BYTES; j++) r_io_w[j] <= WR_RESET;
    end else begin
      r_stb <= w_be;
      for (int i = 0; i < 4; i++) begin
        if (w_wr_en && (3'(i) < w_n)) r_io_w[w_wr_idx + WA'(i)] <= req_wdata[8*i +: 8];
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (w_legal && !req_we) ? w_rdata : 32'd0;
        r_rsp_err   <= !w_legal;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign io_w_stb  = r_stb;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bank.sv
// +--------------------------------------------------------------------------+
// | tb_mmio_bank: directed self-checking bench for mmio_bank.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mmio_bank;

  localparam logic [31:0] c_io   = 32'h1000_0000;
  localparam logic [31:0] c_wr   = 32'h1000_8000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [1:0]   req_dw;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [511:0] io_r;
  logic [511:0] io_w;
  logic [63:0]  io_w_stb;

  int n_pass = 0;
  int n_tot  = 0;

  mmio_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_dw    (req_dw),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .io_r      (io_r),
    .io_w      (io_w),
    .io_w_stb  (io_w_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request presented for exactly one edge; relies on req_ready being high.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] dw);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_dw    = dw;
    tick();
    req_valid = 1'b0;
  endtask

  logic [63:0] seen;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_dw = 2'd0; rsp_ready = 1'b1; io_r = '0;
    tick(); tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_stb",       io_w_stb,       64'd0);
    chk("rst_io_w",      64'(|io_w),     64'd0);
    rst_n = 1'b1;

    // Word write at write-window offset 4.
    do_req(1'b1, c_wr + 32'd4, 32'hDEAD_BEEF, 2'd2);
    chk("wr_word_valid", 64'(rsp_valid), 64'd1);
    chk("wr_word_err",   64'(rsp_err),   64'd0);
    chk("wr_word_rdata", 64'(rsp_rdata), 64'd0);
    chk("wr_word_io_w",  io_w[63:0],     64'hDEAD_BEEF_0000_0000);
    chk("wr_word_stb",   io_w_stb,       64'h0000_0000_0000_00F0);
    tick();
    chk("wr_word_retire", 64'(rsp_valid), 64'd0);
    chk("wr_word_stb_clr", io_w_stb,      64'd0);

    // Reads from the read window.
    io_r[23:16] = 8'hA5;
    io_r[31:24] = 8'h3C;
    io_r[511:480] = 32'h8765_4321;
    do_req(1'b0, c_io + 32'd2, 32'd0, 2'd0);
    chk("rd_byte",       64'(rsp_rdata), 64'h0000_00A5);
    chk("rd_byte_err",   64'(rsp_err),   64'd0);
    do_req(1'b0, c_io + 32'd2, 32'd0, 2'd1);
    chk("rd_half",       64'(rsp_rdata), 64'h0000_3CA5);
    do_req(1'b0, c_io + 32'd60, 32'd0, 2'd2);
    chk("rd_word_end",   64'(rsp_rdata), 64'h8765_4321);
    chk("rd_word_end_err", 64'(rsp_err), 64'd0);
    do_req(1'b0, c_wr + 32'd4, 32'd0, 2'd2);
    chk("rd_back",       64'(rsp_rdata), 64'hDEAD_BEEF);

    // Illegal accesses.
    do_req(1'b1, c_wr + 32'd1, 32'h0000_1234, 2'd1);
    chk("e_misalign_err",   64'(rsp_err),   64'd1);
    chk("e_misalign_rdata", 64'(rsp_rdata), 64'd0);
    chk("e_misalign_stb",   io_w_stb,       64'd0);
    chk("e_misalign_io_w",  io_w[63:0],     64'hDEAD_BEEF_0000_0000);
    do_req(1'b0, c_io + 32'd62, 32'd0, 2'd2);
    chk("e_straddle_err",   64'(rsp_err),   64'd1);
    chk("e_straddle_rdata", 64'(rsp_rdata), 64'd0);
    do_req(1'b1, c_io, 32'hFFFF_FFFF, 2'd2);
    chk("e_wr_rdwin_err",   64'(rsp_err),   64'd1);
    chk("e_wr_rdwin_stb",   io_w_stb,       64'd0);
    chk("e_wr_rdwin_io_w",  io_w[63:0],     64'hDEAD_BEEF_0000_0000);
    do_req(1'b0, c_io, 32'd0, 2'd3);
    chk("e_dw3_err",        64'(rsp_err),   64'd1);
    chk("e_dw3_rdata",      64'(rsp_rdata), 64'd0);
    do_req(1'b0, c_io + 32'd64, 32'd0, 2'd0);
    chk("e_outside_err",    64'(rsp_err),   64'd1);
    do_req(1'b0, c_io + 32'd2, 32'd0, 2'd0);
    chk("ok_after_err",     64'(rsp_err),   64'd0);

    // Backpressure with a second request pending.
    rsp_ready = 1'b0;
    do_req(1'b0, c_io + 32'd2, 32'd0, 2'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = c_io + 32'd2; req_dw = 2'd1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_valid",     64'(rsp_valid), 64'd1);
      chk("bp_rdata",     64'(rsp_rdata), 64'h0000_00A5);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_second_valid", 64'(rsp_valid), 64'd1);
    chk("bp_second_rdata", 64'(rsp_rdata), 64'h0000_3CA5);

    // Back-to-back write then readback, then reset mid-operation.
    do_req(1'b1, c_wr, 32'h0000_005A, 2'd0);
    chk("b2b_io_w0", 64'(io_w[7:0]), 64'h5A);
    chk("b2b_stb",   io_w_stb,       64'd1);
    do_req(1'b0, c_wr, 32'd0, 2'd0);
    chk("b2b_rdata", 64'(rsp_rdata), 64'h0000_005A);
    chk("b2b_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = c_io + 32'd2; req_dw = 2'd0;
    tick();
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_io_w0", 64'(io_w[7:0]), 64'h00);
    chk("mid_rst_io_w",  64'(|io_w),     64'd0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    tick();
    chk("mid_rst_no_accept", 64'(rsp_valid), 64'd0);

    // Byte-write sweep across every write offset.
    seen = '0;
    for (int k = 0; k < 64; k++) begin
      do_req(1'b1, c_wr + 32'(k), 32'(k + 1), 2'd0);
      chk("sweep_stb", io_w_stb, 64'd1 << k);
      seen = seen | io_w_stb;
    end
    tick();
    chk("sweep_stb_clr", io_w_stb, 64'd0);
    chk("sweep_all_seen", seen, {64{1'b1}});
    chk("sweep_io_w_lo", io_w[63:0], 64'h0807_0605_0403_0201);
    chk("sweep_io_w_hi", io_w[511:448], 64'h403F_3E3D_3C3B_3A39);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
